// File: rtl/btb_port_arbiter_if.sv
// Port bundle for the BTB port arbiter: fetch lookup, execute update,
// flush control and the single-port table access bus.
interface btb_port_arbiter_if;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        fetch_gnt;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_ready;
  logic        flush_req;
  logic        flush_busy;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wvalid;

  modport master (
    output fetch_req, fetch_pc, upd_valid, upd_pc, upd_target, flush_req,
    input  fetch_gnt, upd_ready, flush_busy,
           mem_en, mem_we, mem_addr, mem_wdata, mem_wvalid
  );

  modport slave (
    input  fetch_req, fetch_pc, upd_valid, upd_pc, upd_target, flush_req,
    output fetch_gnt, upd_ready, flush_busy,
           mem_en, mem_we, mem_addr, mem_wdata, mem_wvalid
  );
endinterface

// File: rtl/btb_port_arbiter.sv
// Arbitrates a single-port 256-entry BTB between fetch lookups, queued
// execute-stage updates (with starvation forcing) and a full-table flush walk.
module btb_port_arbiter #(
  parameter int unsigned QDEPTH     = 4,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst,
  btb_port_arbiter_if.slave bus
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t         state, state_nxt;
  logic [7:0]     walk;
  logic [7:0]     q_idx [QDEPTH];
  logic [31:0]    q_tgt [QDEPTH];
  logic [PW-1:0]  head, tail;
  logic [CW-1:0]  count;
  logic [SW-1:0]  starve_cnt;

  logic empty, full, idle, upd_prio, upd_issue, push, pop, flush_start;
  logic unused_pc_bits;

  assign empty       = (count == '0);
  assign full        = (count == CW'(QDEPTH));
  assign idle        = !rst && (state == IDLE);
  assign upd_prio    = !empty && (full || (starve_cnt == SW'(STARVE_MAX)));
  assign upd_issue   = idle && !empty && (upd_prio || !bus.fetch_req);
  assign push        = bus.upd_valid && bus.upd_ready;
  assign pop         = upd_issue;
  assign flush_start = (state == IDLE) && bus.flush_req;

  assign unused_pc_bits = ^{bus.fetch_pc[31:10], bus.fetch_pc[1:0],
                            bus.upd_pc[31:10], bus.upd_pc[1:0]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.flush_req) state_nxt = FLUSH;
      FLUSH:   if (walk == 8'hFF) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.fetch_gnt  = idle && bus.fetch_req && !upd_prio;
    bus.upd_ready  = idle && !full;
    bus.flush_busy = !rst && (state == FLUSH);
    bus.mem_en     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    bus.mem_wvalid = 1'b0;
    if (!rst) begin
      if (state == FLUSH) begin
        bus.mem_en   = 1'b1;
        bus.mem_we   = 1'b1;
        bus.mem_addr = walk;
      end else if (upd_issue) begin
        bus.mem_en     = 1'b1;
        bus.mem_we     = 1'b1;
        bus.mem_wvalid = 1'b1;
        bus.mem_addr   = q_idx[head];
        bus.mem_wdata  = q_tgt[head];
      end else if (bus.fetch_gnt) begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = bus.fetch_pc[9:2];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_idx[tail] <= bus.upd_pc[9:2];
      q_tgt[tail] <= bus.upd_target;
    end
  end

  // Entering the flush walk discards the queue outright, overriding any
  // push or pop arbitrated in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      starve_cnt <= '0;
      walk       <= '0;
    end else begin
      if (state == FLUSH) walk <= walk + 8'd1;
      if (flush_start) begin
        head       <= '0;
        tail       <= '0;
        count      <= '0;
        starve_cnt <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        if (upd_issue || empty)
          starve_cnt <= '0;
        else if ((state == IDLE) && (starve_cnt != SW'(STARVE_MAX)))
          starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_btb_port_arbiter.sv
// Directed self-checking bench for btb_port_arbiter: fetch, update, starvation,
// queue-full, flush walk and reset-during-flush scenarios.
module tb_btb_port_arbiter;
  logic clk;
  logic rst;
  int unsigned tests;
  int unsigned failed;

  btb_port_arbiter_if bus ();

  btb_port_arbiter #(.QDEPTH(4), .STARVE_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst_outputs(input string tag);
    chk({tag, "_gnt"},   {31'd0, bus.fetch_gnt},  32'd0);
    chk({tag, "_ready"}, {31'd0, bus.upd_ready},  32'd0);
    chk({tag, "_busy"},  {31'd0, bus.flush_busy}, 32'd0);
    chk({tag, "_en"},    {31'd0, bus.mem_en},     32'd0);
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst = 1'b1;
    bus.fetch_req  = 1'b1;
    bus.fetch_pc   = 32'h0000_0104;
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = 32'h0;
    bus.upd_target = 32'h0;
    bus.flush_req  = 1'b0;

    // reset holds outputs low even with requests pending
    cyc(); cyc(); #1;
    chk_rst_outputs("reset");

    cyc();
    rst = 1'b0;
    bus.fetch_req = 1'b0;
    bus.upd_valid = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, bus.upd_ready},  32'd1);
    chk("post_rst_en",    {31'd0, bus.mem_en},     32'd0);
    chk("post_rst_busy",  {31'd0, bus.flush_busy}, 32'd0);

    // fetch-only
    cyc();
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = 32'h0000_0104;
    #1;
    chk("fetch_gnt",  {31'd0, bus.fetch_gnt}, 32'd1);
    chk("fetch_en",   {31'd0, bus.mem_en},    32'd1);
    chk("fetch_we",   {31'd0, bus.mem_we},    32'd0);
    chk("fetch_addr", {24'd0, bus.mem_addr},  32'h41);

    // update in an idle cycle
    cyc();
    bus.fetch_req  = 1'b0;
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = 32'h0000_0020;
    bus.upd_target = 32'h0000_0400;
    #1;
    chk("upd_push_ready", {31'd0, bus.upd_ready}, 32'd1);
    chk("upd_push_en",    {31'd0, bus.mem_en},    32'd0);
    cyc();
    bus.upd_valid = 1'b0;
    #1;
    chk("upd_we",     {31'd0, bus.mem_we},     32'd1);
    chk("upd_en",     {31'd0, bus.mem_en},     32'd1);
    chk("upd_addr",   {24'd0, bus.mem_addr},   32'h08);
    chk("upd_wdata",  bus.mem_wdata,           32'h400);
    chk("upd_wvalid", {31'd0, bus.mem_wvalid}, 32'd1);
    cyc(); #1;
    chk("upd_drained_en", {31'd0, bus.mem_en}, 32'd0);

    // starvation: one update behind continuous fetch
    cyc();
    bus.fetch_req  = 1'b1;
    bus.fetch_pc   = 32'h0000_0200;
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = 32'h0000_0030;
    bus.upd_target = 32'h0000_1234;
    #1;
    chk("starve_c0_gnt", {31'd0, bus.fetch_gnt}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      bus.upd_valid = 1'b0;
      #1;
      chk($sformatf("starve_c%0d_gnt", i), {31'd0, bus.fetch_gnt}, 32'd1);
      chk($sformatf("starve_c%0d_we", i),  {31'd0, bus.mem_we},    32'd0);
    end
    cyc(); #1;
    chk("starve_c5_gnt",   {31'd0, bus.fetch_gnt}, 32'd0);
    chk("starve_c5_we",    {31'd0, bus.mem_we},    32'd1);
    chk("starve_c5_addr",  {24'd0, bus.mem_addr},  32'h0C);
    chk("starve_c5_wdata", bus.mem_wdata,          32'h1234);
    cyc(); #1;
    chk("starve_c6_gnt", {31'd0, bus.fetch_gnt}, 32'd1);
    chk("starve_c6_we",  {31'd0, bus.mem_we},    32'd0);

    // queue full: four pushes under continuous fetch
    for (int i = 0; i < 4; i++) begin
      cyc();
      bus.upd_valid  = 1'b1;
      bus.upd_pc     = 32'h0000_0040 + 32'(i * 4);
      bus.upd_target = 32'h0000_0100 + 32'(i);
      #1;
      chk($sformatf("full_push%0d_ready", i), {31'd0, bus.upd_ready}, 32'd1);
      chk($sformatf("full_push%0d_gnt", i),   {31'd0, bus.fetch_gnt}, 32'd1);
    end
    cyc();
    bus.upd_valid = 1'b0;
    #1;
    chk("full_ready", {31'd0, bus.upd_ready}, 32'd0);
    chk("full_gnt",   {31'd0, bus.fetch_gnt}, 32'd0);
    chk("full_we",    {31'd0, bus.mem_we},    32'd1);
    chk("full_addr",  {24'd0, bus.mem_addr},  32'h10);
    chk("full_wdata", bus.mem_wdata,          32'h100);
    for (int i = 1; i < 4; i++) begin
      cyc();
      bus.fetch_req = 1'b0;
      #1;
      chk($sformatf("drain%0d_ready", i), {31'd0, bus.upd_ready}, 32'd1);
      chk($sformatf("drain%0d_addr", i),  {24'd0, bus.mem_addr},  32'h10 + 32'(i));
      chk($sformatf("drain%0d_wdata", i), bus.mem_wdata,          32'h100 + 32'(i));
    end
    cyc(); #1;
    chk("drain_done_en", {31'd0, bus.mem_en}, 32'd0);

    // flush with two updates queued
    cyc();
    bus.fetch_req  = 1'b1;
    bus.upd_valid  = 1'b1;
    bus.upd_pc     = 32'h0000_0080;
    bus.upd_target = 32'h0000_00AA;
    #1;
    chk("fl_push0_ready", {31'd0, bus.upd_ready}, 32'd1);
    cyc();
    bus.upd_pc     = 32'h0000_0084;
    bus.upd_target = 32'h0000_00BB;
    #1;
    chk("fl_push1_ready", {31'd0, bus.upd_ready}, 32'd1);
    cyc();
    bus.upd_valid = 1'b0;
    bus.flush_req = 1'b1;
    #1;
    chk("fl_req_gnt",  {31'd0, bus.fetch_gnt},  32'd1);
    chk("fl_req_busy", {31'd0, bus.flush_busy}, 32'd0);
    for (int i = 0; i < 256; i++) begin
      cyc();
      bus.flush_req = (i == 100);
      bus.upd_valid = 1'b1;
      #1;
      chk($sformatf("fl%0d_en", i),     {31'd0, bus.mem_en},     32'd1);
      chk($sformatf("fl%0d_we", i),     {31'd0, bus.mem_we},     32'd1);
      chk($sformatf("fl%0d_addr", i),   {24'd0, bus.mem_addr},   32'(i));
      chk($sformatf("fl%0d_wvalid", i), {31'd0, bus.mem_wvalid}, 32'd0);
      chk($sformatf("fl%0d_wdata", i),  bus.mem_wdata,           32'd0);
      chk($sformatf("fl%0d_busy", i),   {31'd0, bus.flush_busy}, 32'd1);
      chk($sformatf("fl%0d_gnt", i),    {31'd0, bus.fetch_gnt},  32'd0);
      chk($sformatf("fl%0d_ready", i),  {31'd0, bus.upd_ready},  32'd0);
    end
    cyc();
    bus.flush_req = 1'b0;
    bus.upd_valid = 1'b0;
    bus.fetch_req = 1'b0;
    #1;
    chk("fl_done_busy",  {31'd0, bus.flush_busy}, 32'd0);
    chk("fl_done_ready", {31'd0, bus.upd_ready},  32'd1);
    chk("fl_done_en",    {31'd0, bus.mem_en},     32'd0);

    // reset in the middle of a flush walk
    cyc();
    bus.flush_req = 1'b1;
    #1;
    chk("rf_req_en", {31'd0, bus.mem_en}, 32'd0);
    for (int i = 0; i < 50; i++) begin
      cyc();
      bus.flush_req = 1'b0;
      #1;
      chk($sformatf("rf%0d_addr", i), {24'd0, bus.mem_addr}, 32'(i));
    end
    cyc(); #1;
    chk("rf50_addr", {24'd0, bus.mem_addr},   32'd50);
    chk("rf50_busy", {31'd0, bus.flush_busy}, 32'd1);
    rst = 1'b1;
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = 32'h0000_03FC;
    bus.upd_valid = 1'b1;
    #1;
    chk_rst_outputs("rf_rst0");
    cyc(); #1;
    chk_rst_outputs("rf_rst1");
    cyc();
    rst = 1'b0;
    bus.upd_valid = 1'b0;
    #1;
    chk("rf_after_busy",  {31'd0, bus.flush_busy}, 32'd0);
    chk("rf_after_ready", {31'd0, bus.upd_ready},  32'd1);
    chk("rf_after_gnt",   {31'd0, bus.fetch_gnt},  32'd1);
    chk("rf_after_we",    {31'd0, bus.mem_we},     32'd0);
    chk("rf_after_addr",  {24'd0, bus.mem_addr},   32'hFF);
    cyc();
    bus.fetch_req = 1'b0;
    #1;
    chk("rf_idle_en",   {31'd0, bus.mem_en},     32'd0);
    chk("rf_idle_busy", {31'd0, bus.flush_busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/btb_port_arbiter.md
BTB_PORT_ARBITER -- requirements
Module: btb_port_arbiter

Interface
REQ-001 Parameter: QDEPTH, default 4, depth of the pending-update queue (power of two, >= 2).
REQ-002 Parameter: STARVE_MAX, default 4, number of consecutive lost arbitration cycles before a queued update is forced.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: fetch_req  input  1  fetch-stage lookup request.
REQ-006 Port: fetch_pc  input  32  fetch PC; index = fetch_pc[9:2].
REQ-007 Port: fetch_gnt  output  1  lookup issued to the table this cycle.
REQ-008 Port: upd_valid  input  1  execute-stage update offered.
REQ-009 Port: upd_pc  input  32  resolved branch PC; index = upd_pc[9:2].
REQ-010 Port: upd_target  input  32  resolved branch destination.
REQ-011 Port: upd_ready  output  1  update is accepted when upd_valid && upd_ready.
REQ-012 Port: flush_req  input  1  single-cycle request to invalidate all entries.
REQ-013 Port: flush_busy  output  1  flush walk in progress.
REQ-014 Port: mem_en  output  1  table access this cycle.
REQ-015 Port: mem_we  output  1  access is a write.
REQ-016 Port: mem_addr  output  8  table index.
REQ-017 Port: mem_wdata  output  32  write target.
REQ-018 Port: mem_wvalid  output  1  valid bit to be written with the entry.

Function
REQ-019 The block SHALL arbitrate one single-port 256-entry table between fetch lookups, queued updates and flush writes, with at most one access per cycle.
REQ-020 The FSM SHALL have two states: IDLE and FLUSH; IDLE->FLUSH on flush_req in IDLE; FLUSH->IDLE after the write to index 255.
REQ-021 In FLUSH, the block SHALL write mem_we=1, mem_wvalid=0 and mem_wdata=0, with mem_addr set to a walk counter running 0..255, for exactly 256 consecutive cycles.
REQ-022 In FLUSH, the block SHALL hold fetch_gnt=0 and upd_ready=0, and SHALL drive flush_busy=1.
REQ-023 On the IDLE->FLUSH transition edge, the update queue SHALL be emptied; pending updates are discarded.
REQ-024 A flush_req asserted while in FLUSH SHALL be ignored; the walk SHALL NOT restart.
REQ-025 The update queue SHALL be a FIFO of {index, target}; upd_ready = !full && state==IDLE, combinational from registered state.
REQ-026 In IDLE, a dequeued update SHALL be issued as mem_we=1, mem_wvalid=1, mem_addr=head index and mem_wdata=head target, and SHALL pop in that same cycle.
REQ-027 In IDLE, update priority SHALL apply when the queue is non-empty and (queue full or starve_cnt == STARVE_MAX); otherwise fetch_req wins, and the head update issues only when fetch_req=0.
REQ-028 fetch_gnt SHALL equal fetch_req && IDLE && !update-priority; on grant, the block SHALL drive mem_en=1, mem_we=0 and mem_addr=fetch_pc[9:2].
REQ-029 starve_cnt SHALL increment (saturating at STARVE_MAX) on each IDLE cycle in which the queue is non-empty and no update issues, and SHALL clear when an update issues or the queue is empty.
REQ-030 A simultaneous push and pop SHALL keep the occupancy unchanged; a push while full cannot occur, because upd_ready is 0.
REQ-031 Pointers SHALL wrap modulo QDEPTH; occupancy SHALL be held in a counter of log2(QDEPTH)+1 bits.
REQ-032 With no access in a cycle, mem_en, mem_we and mem_wvalid SHALL be 0; mem_addr and mem_wdata are don't-care.
REQ-033 All mem_* outputs and fetch_gnt SHALL be combinational with zero latency; state SHALL update at the clock edge.

Reset
REQ-034 While rst=1, the block SHALL hold: state IDLE, queue empty, starve_cnt 0, walk counter 0.
REQ-035 While rst=1, the block SHALL drive fetch_gnt=0, upd_ready=0, flush_busy=0 and mem_en=0.
REQ-036 A rst during FLUSH SHALL abort the walk and discard the queue; the first cycle after reset SHALL have upd_ready=1.
REQ-037 Reset SHALL NOT trigger a flush; table invalidation requires flush_req.

Verification
REQ-038 The bench SHALL cover fetch-only traffic: fetch_req=1 with fetch_pc=0x0000_0104 -> fetch_gnt=1, mem_en=1, mem_we=0, mem_addr=0x41 in the same cycle.
REQ-039 The bench SHALL cover an update in an idle cycle: push pc 0x0000_0020, target 0x0000_0400, then fetch_req=0 -> next cycle mem_we=1, mem_addr=0x08, mem_wdata=0x400, mem_wvalid=1.
REQ-040 The bench SHALL cover starvation: fetch_req held at 1 with one update queued -> update issues on the 5th cycle after enqueue with fetch_gnt=0, then fetch_gnt resumes.
REQ-041 The bench SHALL cover queue full: 4 pushes with fetch_req=1 -> upd_ready=0; next cycle update issues, and upd_ready=1 the following cycle.
REQ-042 The bench SHALL cover flush: flush_req with 2 updates queued -> 256 writes to addr 0..255 with mem_wvalid=0, flush_busy=1 throughout, queue empty afterwards, a second flush_req at walk index 100 ignored.
REQ-043 The bench SHALL cover reset mid-flush: rst at walk index 50 -> all outputs per REQ-035 while rst=1, then IDLE with flush_busy=0.
